// File: rtl/prf_int_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prf_wb_pkg
// Purpose  : Shared types and constants for the integer PRF writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package prf_wb_pkg;

  localparam int PRF_WB_N_REQ      = 4;
  localparam int PRF_WB_N_WAYS     = 2;
  localparam int PRF_WB_IDX_W      = 6;
  localparam int PRF_WB_DATA_W     = 32;
  localparam int PRF_WB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [PRF_WB_IDX_W-1:0]  index;
    logic [PRF_WB_DATA_W-1:0] data;
  } wb_entry_t;

  // Index width that stays legal when only a single item is being selected.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_wrap(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage : prf_wb_pkg
`default_nettype wire

// File: rtl/prf_int_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : prf_int_wb_arbiter_if
// Purpose  : Requester push bundle and writeback way bundle of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface prf_int_wb_arbiter_if
  import prf_wb_pkg::*;
#(
  parameter int N_REQ  = PRF_WB_N_REQ,
  parameter int N_WAYS = PRF_WB_N_WAYS,
  parameter int IDX_W  = PRF_WB_IDX_W,
  parameter int DATA_W = PRF_WB_DATA_W
);

  localparam int SRC_W = clog2_min1(N_REQ);

  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0][IDX_W-1:0]   req_index;
  logic [N_REQ-1:0][DATA_W-1:0]  req_data;
  logic [N_REQ-1:0]              req_ready;

  logic [N_WAYS-1:0]             wb_valid;
  logic [N_WAYS-1:0][IDX_W-1:0]  wb_index;
  logic [N_WAYS-1:0][DATA_W-1:0] wb_data;
  logic [N_WAYS-1:0][SRC_W-1:0]  wb_src;

  // Environment side: functional units pushing, PRF/scoreboard consuming.
  modport master (
    output req_valid, req_index, req_data,
    input  req_ready, wb_valid, wb_index, wb_data, wb_src
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_index, req_data,
    output req_ready, wb_valid, wb_index, wb_data, wb_src
  );

endinterface : prf_int_wb_arbiter_if
`default_nettype wire

// File: rtl/prf_int_wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : prf_wb_fifo
// Purpose  : Single-requester result FIFO with push/pop, head view, count and
//            synchronous clear. DEPTH must be a power of two, >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module prf_wb_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule : prf_wb_fifo
`default_nettype wire

// File: rtl/prf_int_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prf_int_wb_arbiter
// Purpose  : Per-requester FIFOs feeding a rotating-priority multi-grant
//            arbiter onto the integer PRF writeback ways.
//            Optional feature macro: PRF_WB_ARB_BYPASS_EN (0-cycle bypass of
//            an empty FIFO when its live input wins a way).
// Revision : 1.0 - initial release
// ============================================================================
module prf_int_wb_arbiter
  import prf_wb_pkg::*;
#(
  parameter int N_REQ      = PRF_WB_N_REQ,
  parameter int N_WAYS     = PRF_WB_N_WAYS,
  parameter int IDX_W      = PRF_WB_IDX_W,
  parameter int DATA_W     = PRF_WB_DATA_W,
  parameter int FIFO_DEPTH = PRF_WB_FIFO_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  prf_int_wb_arbiter_if.slave  bus
);

  localparam int SRC_W = clog2_min1(N_REQ);
  localparam int WAY_W = clog2_min1(N_WAYS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = IDX_W + DATA_W;

  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic             flush;
  logic [N_REQ-1:0] fifo_push;
  logic [N_REQ-1:0] fifo_pop;
  logic [N_REQ-1:0] fifo_empty;
  logic [N_REQ-1:0] fifo_full;
  logic [N_REQ-1:0] live;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] bypass_take;
  logic [N_REQ-1:0] cand_valid;
  logic [ENT_W-1:0] head_raw   [N_REQ];
  logic [CNT_W-1:0] fifo_count [N_REQ];
  entry_t           in_entry   [N_REQ];
  entry_t           cand_entry [N_REQ];

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] req_sel;
  logic [WAY_W-1:0] way_sel;
  int               n_ways;

  // Reset and flush have identical effect on all state and on the outputs.
  assign flush = reset || clear;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign in_entry[i]      = '{index: bus.req_index[i], data: bus.req_data[i]};
    assign fifo_empty[i]    = (fifo_count[i] == '0);
    assign fifo_full[i]     = (fifo_count[i] == CNT_W'(FIFO_DEPTH));
    assign bus.req_ready[i] = !fifo_full[i] && !flush;
    // p0 is never busy, so a write to it completes the handshake and vanishes.
    assign live[i]          = bus.req_valid[i] && bus.req_ready[i] &&
                              (bus.req_index[i] != '0);

`ifdef PRF_WB_ARB_BYPASS_EN
    assign cand_valid[i]  = !fifo_empty[i] || live[i];
    assign cand_entry[i]  = fifo_empty[i] ? in_entry[i] : entry_t'(head_raw[i]);
    assign bypass_take[i] = grant[i] && fifo_empty[i];
`else
    assign cand_valid[i]  = !fifo_empty[i];
    assign cand_entry[i]  = entry_t'(head_raw[i]);
    assign bypass_take[i] = 1'b0;
`endif

    assign fifo_push[i] = live[i] && !bypass_take[i];
    assign fifo_pop[i]  = grant[i] && !fifo_empty[i];

    prf_wb_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock     (clock),
      .clear     (flush),
      .push      (fifo_push[i]),
      .push_data (in_entry[i]),
      .pop       (fifo_pop[i]),
      .head      (head_raw[i]),
      .count     (fifo_count[i])
    );
  end : g_req

  // Rotating-priority scan: candidates fill ways 0..N_WAYS-1 in scan order.
  always_comb begin
    grant        = '0;
    bus.wb_valid = '0;
    bus.wb_index = '0;
    bus.wb_data  = '0;
    bus.wb_src   = '0;
    rr_ptr_d     = rr_ptr_q;
    req_sel      = '0;
    way_sel      = '0;
    n_ways       = 0;
    if (!flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        req_sel = SRC_W'(rr_wrap(int'(rr_ptr_q), k, N_REQ));
        if (cand_valid[req_sel] && (n_ways < N_WAYS)) begin
          way_sel               = WAY_W'(n_ways);
          grant[req_sel]        = 1'b1;
          bus.wb_valid[way_sel] = 1'b1;
          bus.wb_index[way_sel] = cand_entry[req_sel].index;
          bus.wb_data[way_sel]  = cand_entry[req_sel].data;
          bus.wb_src[way_sel]   = req_sel;
          rr_ptr_d              = SRC_W'(rr_wrap(int'(req_sel), 1, N_REQ));
          n_ways                = n_ways + 1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule : prf_int_wb_arbiter
`default_nettype wire

// File: tb/tb_prf_int_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prf_int_wb_arbiter
// Purpose  : Directed plus randomized bench for prf_int_wb_arbiter, checked
//            every cycle against a queue-based model of the writeback rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prf_int_wb_arbiter;
  import prf_wb_pkg::*;

  localparam int N_REQ  = PRF_WB_N_REQ;
  localparam int N_WAYS = PRF_WB_N_WAYS;
  localparam int IDX_W  = PRF_WB_IDX_W;
  localparam int DATA_W = PRF_WB_DATA_W;
  localparam int DEPTH  = PRF_WB_FIFO_DEPTH;
  localparam int SRC_W  = clog2_min1(N_REQ);

  logic clock = 1'b0;
  logic reset;
  logic clear;

  always #5 clock = ~clock;

  prf_int_wb_arbiter_if #(
    .N_REQ(N_REQ), .N_WAYS(N_WAYS), .IDX_W(IDX_W), .DATA_W(DATA_W)
  ) bus ();

  prf_int_wb_arbiter #(
    .N_REQ(N_REQ), .N_WAYS(N_WAYS), .IDX_W(IDX_W), .DATA_W(DATA_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: one queue of pending results per requester plus the pointer.
  wb_entry_t model_q [N_REQ][$];
  int        model_rr = 0;

  // Per-cycle model decisions, shared between settle() and advance().
  bit               flushing;
  logic [N_REQ-1:0] exp_ready;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] granted;
  logic [N_REQ-1:0] bypassed;
  logic [N_WAYS-1:0] exp_valid;
  logic [IDX_W-1:0]  exp_index [N_WAYS];
  logic [DATA_W-1:0] exp_data  [N_WAYS];
  logic [SRC_W-1:0]  exp_src   [N_WAYS];
  int n_grant;
  int last_grant;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_index = '0;
    bus.req_data  = '0;
  endtask

  task automatic drive(input int i, input bit v, input int idx, input logic [DATA_W-1:0] dat);
    bus.req_valid[i] = v;
    bus.req_index[i] = IDX_W'(idx);
    bus.req_data[i]  = dat;
  endtask

  // Evaluate the model for the current cycle and compare every output.
  task automatic settle();
    wb_entry_t e;
    int r;
    @(negedge clock);
    flushing   = reset || clear;
    granted    = '0;
    bypassed   = '0;
    exp_valid  = '0;
    n_grant    = 0;
    last_grant = 0;
    for (int j = 0; j < N_WAYS; j++) begin
      exp_index[j] = '0;
      exp_data[j]  = '0;
      exp_src[j]   = '0;
    end
    for (int i = 0; i < N_REQ; i++) begin
      exp_ready[i] = !flushing && (model_q[i].size() < DEPTH);
      accept[i]    = bus.req_valid[i] && exp_ready[i] && (bus.req_index[i] != 0);
    end
    if (!flushing) begin
      for (int k = 0; k < N_REQ; k++) begin
        r = (model_rr + k) % N_REQ;
        if (n_grant < N_WAYS) begin
          if (model_q[r].size() > 0) begin
            e = model_q[r][0];
            granted[r] = 1'b1;
          end
`ifdef PRF_WB_ARB_BYPASS_EN
          else if (accept[r]) begin
            e.index = bus.req_index[r];
            e.data  = bus.req_data[r];
            granted[r]  = 1'b1;
            bypassed[r] = 1'b1;
          end
`endif
          if (granted[r]) begin
            exp_valid[n_grant] = 1'b1;
            exp_index[n_grant] = e.index;
            exp_data[n_grant]  = e.data;
            exp_src[n_grant]   = SRC_W'(r);
            n_grant++;
            last_grant = r;
          end
        end
      end
    end
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check("wb_valid", 64'(bus.wb_valid), 64'(exp_valid));
    for (int j = 0; j < N_WAYS; j++) begin
      check($sformatf("wb_index[%0d]", j), 64'(bus.wb_index[j]), 64'(exp_index[j]));
      check($sformatf("wb_data[%0d]", j), 64'(bus.wb_data[j]), 64'(exp_data[j]));
      check($sformatf("wb_src[%0d]", j), 64'(bus.wb_src[j]), 64'(exp_src[j]));
    end
  endtask

  // Commit the model for this cycle, then move past the next posedge.
  task automatic advance();
    wb_entry_t e;
    if (flushing) begin
      for (int i = 0; i < N_REQ; i++) model_q[i].delete();
      model_rr = 0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (granted[i] && !bypassed[i]) void'(model_q[i].pop_front());
        if (accept[i] && !bypassed[i]) begin
          e.index = bus.req_index[i];
          e.data  = bus.req_data[i];
          model_q[i].push_back(e);
        end
      end
      if (n_grant > 0) model_rr = (last_grant + 1) % N_REQ;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    idle();
    @(posedge clock);
    #1;

    // Reset state
    settle();
    check("rst_req_ready", 64'(bus.req_ready), 64'h0);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'h0);
    check("rst_wb_data0", 64'(bus.wb_data[0]), 64'h0);
    advance();
    step();
    reset = 1'b0;
    settle();
    check("post_rst_ready", 64'(bus.req_ready), 64'hF);
    advance();

    // Single push of p5 / 0xAB from requester 0
    drive(0, 1'b1, 5, 32'hAB);
    settle();
`ifdef PRF_WB_ARB_BYPASS_EN
    check("single_bypass_valid", 64'(bus.wb_valid), 64'h1);
`else
    check("single_push_cycle_valid", 64'(bus.wb_valid), 64'h0);
`endif
    advance();
    idle();
    settle();
`ifndef PRF_WB_ARB_BYPASS_EN
    check("single_wb_valid", 64'(bus.wb_valid), 64'h1);
    check("single_wb_index", 64'(bus.wb_index[0]), 64'd5);
    check("single_wb_data", 64'(bus.wb_data[0]), 64'hAB);
    check("single_wb_src", 64'(bus.wb_src[0]), 64'd0);
`endif
    advance();
    settle();
    check("single_idle_after", 64'(bus.wb_valid), 64'h0);
    advance();

    // Flush to bring rr_ptr back to 0, then all four push together
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < N_REQ; i++) drive(i, 1'b1, i + 1, 32'h100 + i);
    settle();
`ifdef PRF_WB_ARB_BYPASS_EN
    check("cont_byp_src0", 64'(bus.wb_src[0]), 64'd0);
    check("cont_byp_src1", 64'(bus.wb_src[1]), 64'd1);
    advance();
    idle();
    settle();
    check("cont_byp_c1_src0", 64'(bus.wb_src[0]), 64'd2);
    check("cont_byp_c1_src1", 64'(bus.wb_src[1]), 64'd3);
    advance();
`else
    advance();
    idle();
    settle();
    check("cont_c1_valid", 64'(bus.wb_valid), 64'h3);
    check("cont_c1_src0", 64'(bus.wb_src[0]), 64'd0);
    check("cont_c1_src1", 64'(bus.wb_src[1]), 64'd1);
    advance();
    settle();
    check("cont_c2_src0", 64'(bus.wb_src[0]), 64'd2);
    check("cont_c2_src1", 64'(bus.wb_src[1]), 64'd3);
    check("cont_c2_data1", 64'(bus.wb_data[1]), 64'h103);
    advance();
`endif
    settle();
    check("cont_drained", 64'(bus.wb_valid), 64'h0);
    advance();

    // Backpressure on requester 1 while 0, 2, 3 keep the ways busy
    for (int c = 0; c < 5; c++) begin
      drive(0, 1'b1, 10, 32'h1000 + c);
      drive(1, c > 0, 11, 32'h1100 + c);
      drive(2, 1'b1, 12, 32'h1200 + c);
      drive(3, 1'b1, 13, 32'h1300 + c);
      settle();
`ifndef PRF_WB_ARB_BYPASS_EN
      if (c == 3) check("bp_ready1_full", 64'(bus.req_ready[1]), 64'h0);
      if (c == 4) check("bp_ready1_credit", 64'(bus.req_ready[1]), 64'h1);
`endif
      advance();
    end
    idle();
    for (int c = 0; c < 8; c++) step();

    // A push to p0 is consumed without ever reaching a way
    drive(3, 1'b1, 0, 32'hDEAD);
    settle();
    check("p0_ready", 64'(bus.req_ready[3]), 64'h1);
    advance();
    idle();
    settle();
    check("p0_no_wb", 64'(bus.wb_valid), 64'h0);
    check("p0_ready_after", 64'(bus.req_ready[3]), 64'h1);
    advance();

    // Flush with three FIFOs holding entries
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 20 + i, 32'h2000 + i);
    step();
    idle();
    clear = 1'b1;
    settle();
    check("flush_wb_valid", 64'(bus.wb_valid), 64'h0);
    check("flush_ready", 64'(bus.req_ready), 64'h0);
    advance();
    clear = 1'b0;
    drive(1, 1'b1, 31, 32'h31);
    drive(2, 1'b1, 32, 32'h32);
    drive(3, 1'b1, 33, 32'h33);
    settle();
    check("flush_after_ready", 64'(bus.req_ready), 64'hF);
`ifndef PRF_WB_ARB_BYPASS_EN
    check("flush_after_empty", 64'(bus.wb_valid), 64'h0);
`endif
    advance();
    idle();
    settle();
`ifndef PRF_WB_ARB_BYPASS_EN
    check("flush_rr0_src0", 64'(bus.wb_src[0]), 64'd1);
    check("flush_rr0_src1", 64'(bus.wb_src[1]), 64'd2);
`endif
    advance();
    for (int c = 0; c < 4; c++) step();

`ifdef PRF_WB_ARB_BYPASS_EN
    // Zero-latency path from an empty FIFO
    drive(2, 1'b1, 9, 32'h99);
    settle();
    check("byp_valid", 64'(bus.wb_valid), 64'h1);
    check("byp_index", 64'(bus.wb_index[0]), 64'd9);
    advance();
    idle();
    settle();
    check("byp_not_queued", 64'(bus.wb_valid), 64'h0);
    advance();
`endif

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        drive(i, $urandom_range(0, 99) < 60,
              ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)),
              DATA_W'($urandom));
      end
      clear = ($urandom_range(0, 63) == 0);
      reset = ($urandom_range(0, 255) == 0);
      step();
    end
    reset = 1'b0;
    clear = 1'b0;
    idle();
    for (int c = 0; c < 4; c++) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_prf_int_wb_arbiter
`default_nettype wire
